// File: rtl/rs232c_receiver.sv
// RS-232C frame receiver: 1 start, BIT_WIDTH data bits (LSB first), 1 stop; bit period = max_count+1 clocks.
// Each word is sampled about half a bit after its line edge; results are single-cycle r_valid / frame_err strobes.
module rs232c_receiver #(
    parameter int BIT_WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 n_rst,
    input  logic                 rxd,
    input  logic [31:0]          max_count,
    output logic [BIT_WIDTH-1:0] recv_data,
    output logic                 r_valid,
    output logic                 frame_err,
    output logic                 r_busy
);

    localparam int IW = $clog2(BIT_WIDTH) + 1;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        WAIT_HIGH
    } state_t;

    state_t                 state, state_nx;
    logic                   s1, s2, s_prev;
    logic [31:0]            count, count_nx;
    logic [31:0]            half;
    logic [IW-1:0]          bit_idx, bit_idx_nx;
    logic [BIT_WIDTH-1:0]   shreg, shreg_nx;
    logic [BIT_WIDTH-1:0]   recv_data_nx;
    logic                   r_valid_nx, frame_err_nx;

    assign half   = max_count >> 1;
    assign r_busy = (state != IDLE);

    // rxd is asynchronous; s_prev gives the edge detector a settled previous value
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            s1     <= 1'b1;
            s2     <= 1'b1;
            s_prev <= 1'b1;
        end else begin
            s1     <= rxd;
            s2     <= s1;
            s_prev <= s2;
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state     <= IDLE;
            count     <= '0;
            bit_idx   <= '0;
            shreg     <= '0;
            recv_data <= '0;
            r_valid   <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            state     <= state_nx;
            count     <= count_nx;
            bit_idx   <= bit_idx_nx;
            shreg     <= shreg_nx;
            recv_data <= recv_data_nx;
            r_valid   <= r_valid_nx;
            frame_err <= frame_err_nx;
        end
    end

    always_comb begin
        state_nx     = state;
        count_nx     = count;
        bit_idx_nx   = bit_idx;
        shreg_nx     = shreg;
        recv_data_nx = recv_data;
        r_valid_nx   = 1'b0;
        frame_err_nx = 1'b0;

        case (state)
            IDLE: begin
                if (s_prev && !s2) begin
                    state_nx = START;
                    count_nx = '0;
                end
            end
            START: begin
                // a start bit that is gone by mid-bit is treated as a glitch
                if (count == half) begin
                    count_nx = '0;
                    if (!s2) begin
                        state_nx   = DATA;
                        bit_idx_nx = '0;
                    end else begin
                        state_nx = IDLE;
                    end
                end else begin
                    count_nx = count + 32'd1;
                end
            end
            DATA: begin
                if (count == max_count) begin
                    for (int i = 0; i < BIT_WIDTH; i++) begin
                        if (bit_idx == IW'(i)) shreg_nx[i] = s2;
                    end
                    count_nx   = '0;
                    bit_idx_nx = bit_idx + IW'(1);
                    if (bit_idx == IW'(BIT_WIDTH - 1)) state_nx = STOP;
                end else begin
                    count_nx = count + 32'd1;
                end
            end
            STOP: begin
                if (count == max_count) begin
                    count_nx = '0;
                    if (s2) begin
                        recv_data_nx = shreg;
                        r_valid_nx   = 1'b1;
                        state_nx     = IDLE;
                    end else begin
                        frame_err_nx = 1'b1;
                        state_nx     = WAIT_HIGH;
                    end
                end else begin
                    count_nx = count + 32'd1;
                end
            end
            WAIT_HIGH: begin
                // a held-low line (break) must not start a new frame
                if (s2) begin
                    state_nx = IDLE;
                    count_nx = '0;
                end
            end
            default: begin
                state_nx = IDLE;
                count_nx = '0;
            end
        endcase
    end

endmodule

// File: doc/rs232c_receiver.md
# rs232c_receiver

Asynchronous serial (RS-232C framing) receiver: deserializes 1 start bit, BIT_WIDTH data bits (LSB first) and 1 stop bit from the `rxd` line into a parallel word. It sits directly downstream of the serial line driven by the transmit stage and uses the same runtime bit-period convention: one bit lasts `max_count+1` clocks. Each received word is presented with a single-cycle valid strobe. A bad stop bit raises a single-cycle framing-error strobe instead.

## Interface
- `BIT_WIDTH`, default 8: number of data bits per frame.
- `clk`  in  1  system clock.
- `n_rst`  in  1  reset; asynchronous assert, active-low.
- `rxd`  in  1  serial input; idle level 1; asynchronous to `clk`.
- `max_count`  in  32  bit period minus one, in clocks. Legal range is ≥ 2. Change it only while `r_busy`=0.
- `recv_data`  out  BIT_WIDTH  last good received word; holds until the next good frame.
- `r_valid`  out  1  1-cycle pulse: `recv_data` was updated this cycle.
- `frame_err`  out  1  1-cycle pulse: stop bit sampled as 0; the word is discarded.
- `r_busy`  out  1  high whenever the FSM is not IDLE.

## Operation
- Input synchronizer: `rxd` → `s1` → `s2` → `s_prev`. All three reset to 1.
- Start detect: `s_prev`=1 and `s2`=0 while in IDLE.
- Half period: `h = max_count >> 1`.
- Counter `count` is 32 bits. It clears to 0 on every state change and on every bit sample.
- FSM states and transitions:
  - IDLE: on start detect → START, `count`=0.
  - START: `count` increments each clock. When `count==h`:
    - if `s2`=0 → DATA, `count`=0, `bit_idx`=0;
    - otherwise (glitch) → IDLE.
  - DATA: `count` increments each clock. When `count==max_count`:
    - shift `s2` into the shift register at `bit_idx` (LSB first);
    - `count`=0 and `bit_idx++`;
    - after sampling bit BIT_WIDTH-1 → STOP.
  - STOP: when `count==max_count`, sample `s2`:
    - if 1: `recv_data` ← shift register, `r_valid` pulses → IDLE;
    - if 0: `frame_err` pulses, `recv_data` unchanged → WAIT_HIGH.
  - WAIT_HIGH: stay until `s2`=1, then → IDLE. This prevents a break (line held low) from retriggering frames.
- `bit_idx` is $clog2(BIT_WIDTH)+1 bits wide.
- No receive-enable input. The receiver is always armed when idle.
- Overrun is not flagged. A consumer that misses `r_valid` loses the word.

## Timing
- Reset values:
  - `recv_data`=0, `r_valid`=0, `frame_err`=0, `r_busy`=0;
  - FSM=IDLE, `count`=0, `bit_idx`=0, shift register=0.
- Reset asserted mid-frame: all of the above take effect immediately (asynchronously). The partial frame is discarded with no `r_valid` and no `frame_err`.
- Reset deasserted with `rxd` low: the synchronizer produces a start detect after release. The frame then resolves normally. A persistently low line gives one `frame_err`, then WAIT_HIGH.
- Let `rxd` fall before clock edge k, with M=`max_count` and W=`BIT_WIDTH`:
  - START is entered at edge k+2;
  - DATA is entered at edge k+3+h;
  - data bit i is sampled at edge k+3+h+(i+1)(M+1);
  - the stop bit is sampled at edge k+3+h+(W+1)(M+1). `r_valid`/`frame_err` are high for exactly the cycle after that edge.
- Samples land about h+3 clocks after each line bit edge, i.e. near mid-bit.
- `r_busy` rises at edge k+2. It falls at the stop-sample edge (good frame) or on leaving WAIT_HIGH.
- A back-to-back frame is accepted: its start edge arrives about h clocks after the stop sample, and IDLE is already re-entered by then.
- `r_valid` and `frame_err` are never high together.

## Test plan
- Good frame, M=9, W=8: send 0xA5 (line: 0,1,0,1,0,0,1,0,1,1), each bit 10 clocks, start falling before edge k → `recv_data`=0xA5 and `r_valid`=1 for exactly one cycle after edge k+97; `frame_err` stays 0.
- Back-to-back frames, M=9: send 0x00, 0xFF, 0x3C with no idle gap → three `r_valid` pulses 100 clocks apart with correct data; `r_busy` low for about 5 clocks between frames.
- Framing error, M=9: send 0x5A with stop bit=0, then line low for 30 clocks, then high → one `frame_err` pulse, no `r_valid`, `recv_data` keeps its previous value; `r_busy` falls only after `rxd` returns high.
- Glitch rejection, M=9: pulse `rxd` low for 3 clocks → FSM returns to IDLE at the half-bit check; no `r_valid` or `frame_err`; the next good frame 0x81 is received correctly.
- Reset mid-frame: assert `n_rst` during data bit 4 of a frame → outputs go to reset values immediately; after release with `rxd` high, frame 0x42 is received correctly.
- Minimum and large period: M=2 with 0x96, and M=867 with 0x69 → both received with `r_valid` at the computed edge, and `frame_err`=0.
